// File: rtl/mlp_train_sched.sv
// rtl/mlp_train_sched.sv - train/eval epoch scheduler for a small MLP
// Optional early stop on a perfect eval pass: define MLP_SCHED_EARLY_STOP_EN.
module mlp_train_sched #(
  parameter int NUM_SAMPLES = 4,
  parameter int HOLD        = 2,
  parameter int EPOCH_W     = 16,
  localparam int IDX_W      = $clog2(NUM_SAMPLES)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [EPOCH_W-1:0] max_epochs,
  input  logic               pred_high,
  input  logic               label_high,
  output logic [IDX_W-1:0]   sample_idx,
  output logic               training,
  output logic               busy,
  output logic               done,
  output logic [EPOCH_W-1:0] epoch_cnt,
  output logic [IDX_W:0]     correct_cnt
);

  localparam int HOLD_W = (HOLD > 1) ? $clog2(HOLD) : 1;

  typedef enum logic [1:0] {IDLE, TRAIN, EVAL, DONE} state_t;

  state_t             state, state_n;
  logic [HOLD_W-1:0]  hold_cnt;
  logic [IDX_W:0]     acc;
  logic [EPOCH_W-1:0] max_q;

  logic               last_hold, last_sample, pass_end, match, early_stop;
  logic [IDX_W:0]     acc_next;
  logic [EPOCH_W-1:0] epoch_inc;

  assign last_hold   = (hold_cnt == HOLD_W'(HOLD - 1));
  assign last_sample = (sample_idx == IDX_W'(NUM_SAMPLES - 1));
  assign pass_end    = last_hold && last_sample;
  assign match       = (pred_high == label_high);
  assign acc_next    = acc + {{IDX_W{1'b0}}, match};
  assign epoch_inc   = (epoch_cnt == {EPOCH_W{1'b1}}) ? epoch_cnt : epoch_cnt + EPOCH_W'(1);

`ifdef MLP_SCHED_EARLY_STOP_EN
  assign early_stop = (acc_next == (IDX_W+1)'(NUM_SAMPLES));
`else
  assign early_stop = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  always_comb begin
    state_n  = state;
    training = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    unique case (state)
      IDLE, DONE: begin
        done = (state == DONE);
        if (start) state_n = (max_epochs == '0) ? DONE : TRAIN;
      end
      TRAIN: begin
        training = 1'b1;
        busy     = 1'b1;
        if (pass_end) state_n = EVAL;
      end
      EVAL: begin
        busy = 1'b1;
        if (pass_end) state_n = ((epoch_inc == max_q) || early_stop) ? DONE : TRAIN;
      end
      default: state_n = IDLE;
    endcase
    // abort overrides everything, including a simultaneous start
    if (abort) state_n = IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sample_idx  <= '0;
      hold_cnt    <= '0;
      acc         <= '0;
      epoch_cnt   <= '0;
      correct_cnt <= '0;
      max_q       <= '0;
    end else if (abort) begin
      sample_idx <= '0;
      hold_cnt   <= '0;
      acc        <= '0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            max_q       <= max_epochs;
            epoch_cnt   <= '0;
            correct_cnt <= '0;
            sample_idx  <= '0;
            hold_cnt    <= '0;
            acc         <= '0;
          end
        end
        TRAIN, EVAL: begin
          if (last_hold) begin
            hold_cnt   <= '0;
            sample_idx <= last_sample ? '0 : sample_idx + IDX_W'(1);
          end else begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
          end
          // score on the final hold cycle so the MLP output has settled
          if ((state == EVAL) && last_hold) begin
            if (last_sample) begin
              correct_cnt <= acc_next;
              acc         <= '0;
              epoch_cnt   <= epoch_inc;
            end else begin
              acc <= acc_next;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mlp_train_sched.sv
// tb/tb_mlp_train_sched.sv - directed self-checking bench for mlp_train_sched
// Build with MLP_SCHED_EARLY_STOP_EN defined to exercise early stop.
module tb_mlp_train_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] max_epochs = '0;
  logic        pred_high, label_high;
  logic [1:0]  sample_idx;
  logic        training, busy, done;
  logic [15:0] epoch_cnt;
  logic [2:0]  correct_cnt;
  int          mode = 0;
  int          tests = 0;
  int          fails = 0;
  int          cyc;

  mlp_train_sched dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .max_epochs(max_epochs),
    .pred_high(pred_high), .label_high(label_high), .sample_idx(sample_idx),
    .training(training), .busy(busy), .done(done), .epoch_cnt(epoch_cnt),
    .correct_cnt(correct_cnt)
  );

  always #5 clk = ~clk;

  // mode 1 flips the prediction for sample 1 only
  assign label_high = sample_idx[0];
  assign pred_high  = (mode == 1) ? (label_high ^ (sample_idx == 2'd1)) : label_high;

  task automatic check(input string tag, input longint got, input longint exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic start_run(input logic [15:0] m);
    max_epochs = m;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // counts busy cycles until the run ends; spot-checks the first epoch
  task automatic run_count(output int n, input int exp_correct);
    n = 0;
    while (busy && n < 1000) begin
      if (n < 8) begin
        check("idx_seq", sample_idx, (n / 2) % 4);
        check("train_on", training, 1);
      end
      if (n == 5) start = 1'b1;
      else        start = 1'b0;
      if (n == 8) check("eval_no_train", training, 0);
      if (n == 16) begin
        check("epoch1_cnt", epoch_cnt, 1);
        check("epoch1_correct", correct_cnt, exp_correct);
      end
      n++;
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_train", training, 0);
    check("rst_idx", sample_idx, 0);
    check("rst_epoch", epoch_cnt, 0);
    check("rst_correct", correct_cnt, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    mode = 0;
    start_run(16'd3);
    run_count(cyc, 4);
    check("run3_cycles", cyc, 48);
    check("run3_epoch", epoch_cnt, 3);
    check("run3_correct", correct_cnt, 4);
    check("run3_done", done, 1);
    repeat (3) @(negedge clk);
    check("done_hold", done, 1);

    mode = 1;
    start_run(16'd2);
    run_count(cyc, 3);
    check("run2_cycles", cyc, 32);
    check("run2_correct", correct_cnt, 3);
    check("run2_epoch", epoch_cnt, 2);
    mode = 0;

    start_run(16'd0);
    check("zero_done", done, 1);
    check("zero_train", training, 0);
    check("zero_busy", busy, 0);
    check("zero_epoch", epoch_cnt, 0);

    start_run(16'd5);
    repeat (24) @(negedge clk);
    check("ep2_eval_busy", busy, 1);
    check("ep2_eval_train", training, 0);
    abort = 1'b1;
    start = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    start = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_epoch", epoch_cnt, 1);
    check("abort_idx", sample_idx, 0);
    @(negedge clk);
    check("abort_stays_idle", busy, 0);

    start_run(16'd5);
    repeat (35) @(negedge clk);
    check("ep3_train", training, 1);
    check("ep3_epoch", epoch_cnt, 2);
    #2 rst = 1'b0;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_train", training, 0);
    check("midrst_done", done, 0);
    check("midrst_epoch", epoch_cnt, 0);
    check("midrst_correct", correct_cnt, 0);
    check("midrst_idx", sample_idx, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

`ifdef MLP_SCHED_EARLY_STOP_EN
    start_run(16'd100);
    run_count(cyc, 4);
    check("early_cycles", cyc, 16);
    check("early_epoch", epoch_cnt, 1);
    check("early_done", done, 1);
`else
    start_run(16'd100);
    repeat (20) @(negedge clk);
    check("noearly_busy", busy, 1);
    check("noearly_epoch", epoch_cnt, 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("noearly_abort", busy, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mlp_train_sched.md
MLP_TRAIN_SCHED -- requirements
Module: mlp_train_sched

Interface
REQ-001 SHALL have parameter NUM_SAMPLES, default 4, number of training samples per epoch (>=2).
REQ-002 SHALL have parameter HOLD, default 2, cycles each sample is presented to the MLP (>=1).
REQ-003 SHALL have parameter EPOCH_W, default 16, width of epoch counters.
REQ-004 SHALL have localparam IDX_W = $clog2(NUM_SAMPLES).
REQ-005 SHALL have port: clk  input  1  single clock; all state changes on rising edge.
REQ-006 SHALL have port: rst  input  1  reset, asynchronous and active-low.
REQ-007 SHALL have port: start  input  1  begin a training run; sampled only in IDLE or DONE.
REQ-008 SHALL have port: abort  input  1  synchronous abort of a run.
REQ-009 SHALL have port: max_epochs  input  EPOCH_W  epoch limit; captured at start.
REQ-010 SHALL have port: pred_high  input  1  MLP prediction >= 0.5 for the presented sample.
REQ-011 SHALL have port: label_high  input  1  expected label >= 0.5 for sample_idx.
REQ-012 SHALL have port: sample_idx  output  IDX_W  index of the sample driven to the MLP.
REQ-013 SHALL have port: training  output  1  MLP training enable.
REQ-014 SHALL have port: busy  output  1  high in TRAIN or EVAL.
REQ-015 SHALL have port: done  output  1  high in DONE.
REQ-016 SHALL have port: epoch_cnt  output  EPOCH_W  completed epochs in current run.
REQ-017 SHALL have port: correct_cnt  output  IDX_W+1  correct classifications in the last completed EVAL pass.

Function
REQ-018 SHALL implement FSM states IDLE, TRAIN, EVAL, DONE; training=1 only in TRAIN.
REQ-019 SHALL go IDLE/DONE -> TRAIN on start=1 when captured max_epochs != 0, clearing epoch_cnt, correct_cnt, sample_idx, hold counter.
REQ-020 SHALL go IDLE/DONE -> DONE on start=1 with max_epochs == 0, epoch_cnt=0.
REQ-021 SHALL hold each sample_idx for exactly HOLD cycles, then increment it; after index NUM_SAMPLES-1 wrap to 0.
REQ-022 SHALL go TRAIN -> EVAL when the hold of index NUM_SAMPLES-1 completes, sample_idx wrapping to 0.
REQ-023 SHALL in EVAL compare pred_high with label_high on the last hold cycle of each sample and count matches in an internal accumulator.
REQ-024 SHALL at end of EVAL load correct_cnt with the accumulator (including the final sample's match), increment epoch_cnt, clear the accumulator.
REQ-025 SHALL go EVAL -> DONE when incremented epoch_cnt == captured max_epochs, else EVAL -> TRAIN.
REQ-026 SHALL make one epoch last exactly 2*NUM_SAMPLES*HOLD cycles.
REQ-027 SHALL ignore start while busy=1.
REQ-028 SHALL on abort=1 in any state go to IDLE next cycle, clear sample_idx and accumulator, keep epoch_cnt and correct_cnt; abort wins over start in the same cycle.
REQ-029 SHALL saturate epoch_cnt at all-ones, never wrapping.
REQ-030 SHALL keep DONE until start or abort.

Reset
REQ-031 SHALL on rst=0 asynchronously force IDLE, sample_idx=0, training=0, busy=0, done=0, epoch_cnt=0, correct_cnt=0, accumulator and hold counter 0.
REQ-032 SHALL leave reset synchronously on first rising clk with rst=1; reset mid-run abandons the run with no output retained.

Configuration
REQ-033 SHALL with macro MLP_SCHED_EARLY_STOP_EN defined go EVAL -> DONE also when correct_cnt result == NUM_SAMPLES, regardless of max_epochs.
REQ-034 SHALL with MLP_SCHED_EARLY_STOP_EN undefined stop only on the epoch limit (REQ-025).

Verification
REQ-035 SHALL cover: reset mid-TRAIN at epoch 3 -> all outputs 0, state IDLE in same cycle as rst fall.
REQ-036 SHALL cover: NUM_SAMPLES=4, HOLD=2, max_epochs=3, pred_high=label_high always (without early stop) -> done after 48 cycles, epoch_cnt=3, correct_cnt=4.
REQ-037 SHALL cover: pred_high=~label_high for index 1 only -> correct_cnt=3 after each epoch.
REQ-038 SHALL cover: start with max_epochs=0 -> DONE next cycle, training never asserted, epoch_cnt=0.
REQ-039 SHALL cover: abort and start same cycle in EVAL epoch 2 -> IDLE, epoch_cnt=1 kept, start ignored.
REQ-040 SHALL cover: MLP_SCHED_EARLY_STOP_EN defined, all correct, max_epochs=100 -> DONE after first epoch (16 cycles), epoch_cnt=1.
